// File: rtl/ttt_keypad_scanner.sv
// ttt_keypad_scanner: 3x3 key matrix scanner with frame debounce and one-hot move strobes
module ttt_keypad_scanner #(
  parameter int SCAN_CYCLES    = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] col_in,
  output logic [2:0] row_out,
  output logic [8:0] key_held,
  output logic [8:0] key_pulse,
  output logic       key_valid,
  output logic [3:0] key_code
);
  localparam int DW = $clog2(SCAN_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DLAST = DW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_SCANS);
  logic [1:0]    r_row;
  logic [DW-1:0] r_dwell;
  logic [2:0]    r_sync1, r_col_s;
  logic [8:0]    r_snap, r_cand;
  logic [CW-1:0] r_cnt;
  logic          r_armed;
  logic          w_last, w_frame_end, w_accept, w_move;
  logic [8:0]    w_snap;
  logic [CW-1:0] w_cnt;
  logic [3:0]    w_code;
  assign row_out = 3'b001 << r_row;
  // w_snap already includes the row being sampled this cycle, so frame end sees the whole frame
  always_comb begin
    w_last      = r_dwell == DLAST;
    w_frame_end = w_last && r_row == 2'd2;
    w_snap      = r_snap;
    if (w_last) w_snap[r_row*3 +: 3] = r_col_s;
    w_cnt    = (w_snap != r_cand) ? CW'(1) : (r_cnt == CMAX) ? CMAX : r_cnt + 1'b1;
    w_accept = w_frame_end && w_cnt >= CMAX;
    w_move   = w_accept && r_armed && key_held == '0 && w_snap != '0 &&
               (w_snap & (w_snap - 9'd1)) == '0;
    w_code   = '0;
    for (int i = 0; i < 9; i++) if (w_snap[i]) w_code = 4'(i);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row     <= '0;
      r_dwell   <= '0;
      r_sync1   <= '0;
      r_col_s   <= '0;
      r_snap    <= '0;
      r_cand    <= '0;
      r_cnt     <= '0;
      r_armed   <= 1'b0;
      key_held  <= '0;
      key_pulse <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      r_sync1 <= col_in;
      r_col_s <= r_sync1;
      r_dwell <= w_last ? '0 : r_dwell + 1'b1;
      if (w_last) r_row <= (r_row == 2'd2) ? 2'd0 : r_row + 2'd1;
      r_snap <= w_snap;
      if (w_frame_end) begin
        r_cand <= w_snap;
        r_cnt  <= w_cnt;
      end
      if (w_accept) key_held <= w_snap;
      // only an all-released accept arms, so keys held through reset never strobe
      if (w_accept && w_snap == '0) r_armed <= 1'b1;
      key_pulse <= w_move ? w_snap : '0;
      key_valid <= w_move;
      key_code  <= w_move ? w_code : '0;
    end
  end
endmodule

// File: tb/tb_ttt_keypad_scanner.sv
// tb_ttt_keypad_scanner: directed checks of scan timing, debounce, arming and move strobes
module tb_ttt_keypad_scanner;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] col_in;
  logic [2:0] row_out;
  logic [8:0] key_held, key_pulse;
  logic       key_valid;
  logic [3:0] key_code;
  logic [8:0] keys;
  logic [2:0] glitch;
  int compared = 0, failed = 0, cyc = 0, pulses = 0, pulse_cyc = -1, p;
  logic [8:0] last_pulse = '0, held_seen = '0;
  logic [3:0] last_code = '0;
  ttt_keypad_scanner dut (
    .clk(clk), .reset(reset), .col_in(col_in), .row_out(row_out),
    .key_held(key_held), .key_pulse(key_pulse), .key_valid(key_valid), .key_code(key_code)
  );
  always #5 clk = ~clk;
  assign col_in = glitch | (row_out[0] ? keys[2:0] : row_out[1] ? keys[5:3] : row_out[2] ? keys[8:6] : 3'b000);
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      check("valid_vs_pulse", 16'(key_valid), 16'(|key_pulse));
      if (!key_valid) check("code_idle", 16'(key_code), 16'h0);
      if (key_pulse != '0) begin
        pulses++;
        last_pulse = key_pulse;
        last_code  = key_code;
        pulse_cyc  = cyc;
      end
      held_seen = held_seen | key_held;
    end
  endtask
  initial begin
    reset = 1'b1; keys = '0; glitch = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0; cyc = 0;
    for (int c = 0; c < 36; c++) begin
      check("row_out_scan", 16'(row_out), 16'(3'b001 << ((c / 4) % 3)));
      check("held_after_reset", 16'(key_held), 16'h0);
      check("pulse_after_reset", 16'(key_pulse), 16'h0);
      tick(1);
    end
    check("row_out_wrap", 16'(row_out), 16'h1);
    // key 4 press: strobe on third frame end that sees it
    keys = 9'h010; p = pulses;
    tick(36);
    check("k4_count", 16'(pulses), 16'(p + 1));
    check("k4_cycle", 16'(pulse_cyc), 16'd72);
    check("k4_pulse", 16'(last_pulse), 16'h010);
    check("k4_code", 16'(last_code), 16'd4);
    check("k4_held", 16'(key_held), 16'h010);
    tick(24);
    check("k4_no_repeat", 16'(pulses), 16'(p + 1));
    check("k4_still_held", 16'(key_held), 16'h010);
    keys = '0;
    tick(36);
    check("k4_release_held", 16'(key_held), 16'h0);
    check("k4_release_nopulse", 16'(pulses), 16'(p + 1));
    keys = 9'h010;
    tick(36);
    check("k4_repress_count", 16'(pulses), 16'(p + 2));
    check("k4_repress_cycle", 16'(pulse_cyc), 16'd168);
    check("k4_repress_code", 16'(last_code), 16'd4);
    keys = '0;
    tick(36);
    check("k4_final_release", 16'(key_held), 16'h0);
    // key 7 bounce: present, absent, then steady
    p = pulses;
    keys = 9'h080; tick(12);
    keys = '0;     tick(12);
    keys = 9'h080; tick(36);
    check("k7_count", 16'(pulses), 16'(p + 1));
    check("k7_cycle", 16'(pulse_cyc), 16'd264);
    check("k7_pulse", 16'(last_pulse), 16'h080);
    check("k7_code", 16'(last_code), 16'd7);
    keys = '0; tick(36);
    check("k7_release", 16'(key_held), 16'h0);
    // keys 0 and 8 together, then partial release
    p = pulses;
    keys = 9'h101; tick(36);
    check("k08_held", 16'(key_held), 16'h101);
    check("k08_nopulse", 16'(pulses), 16'(p));
    keys = 9'h001; tick(36);
    check("k0_left_held", 16'(key_held), 16'h001);
    check("k0_left_nopulse", 16'(pulses), 16'(p));
    keys = '0; tick(36);
    check("k08_release", 16'(key_held), 16'h0);
    keys = 9'h001; tick(36);
    check("k0_count", 16'(pulses), 16'(p + 1));
    check("k0_cycle", 16'(pulse_cyc), 16'd444);
    check("k0_pulse", 16'(last_pulse), 16'h001);
    check("k0_code", 16'(last_code), 16'd0);
    keys = '0; tick(36);
    // key 2 held through a mid-frame reset
    keys = 9'h004; tick(17);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0; cyc = 0; p = pulses;
    check("rst_row_out", 16'(row_out), 16'h1);
    check("rst_held", 16'(key_held), 16'h0);
    tick(36);
    check("k2_held_unarmed", 16'(key_held), 16'h004);
    check("k2_unarmed_nopulse", 16'(pulses), 16'(p));
    tick(24);
    check("k2_still_nopulse", 16'(pulses), 16'(p));
    keys = '0; tick(36);
    check("k2_release", 16'(key_held), 16'h0);
    keys = 9'h004; tick(36);
    check("k2_count", 16'(pulses), 16'(p + 1));
    check("k2_cycle", 16'(pulse_cyc), 16'd132);
    check("k2_code", 16'(last_code), 16'd2);
    keys = '0; tick(36);
    check("k2_final_release", 16'(key_held), 16'h0);
    // mid-dwell one-cycle glitch, then a single-frame glitch
    p = pulses; held_seen = '0;
    glitch = 3'b111; tick(1);
    glitch = '0;     tick(11);
    keys = 9'h020;   tick(12);
    keys = '0;       tick(36);
    check("glitch_held_seen", 16'(held_seen), 16'h0);
    check("glitch_nopulse", 16'(pulses), 16'(p));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
